// File: rtl/lcd_refresh_if.sv
// rtl/lcd_refresh_if.sv - Display-list and LCD bus bundle for the refresh controller
interface lcd_refresh_if;
    logic       refresh;
    logic [7:0] char_in;
    logic [4:0] index;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;
    logic       frame_done;

    modport master (
        input  refresh, char_in,
        output index, lcd_e, lcd_rs, lcd_rw, lcd_data, busy, frame_done
    );

    modport slave (
        output refresh, char_in,
        input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, busy, frame_done
    );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - HD44780-style 2x16 LCD init and frame refresh sequencer
module lcd_refresh_ctrl #(
    parameter int PWR_WAIT = 16,
    parameter int E_PULSE  = 4,
    parameter int CMD_WAIT = 8,
    parameter int CLR_WAIT = 32
) (
    input  logic          clk,
    input  logic          rst,
    lcd_refresh_if.master lcd
);
    // One counter serves the power-on wait, the enable pulse and the post-write wait,
    // so it is sized for the largest of them (it counts 0 .. N-1).
    localparam int MAX_A = (PWR_WAIT > E_PULSE) ? PWR_WAIT : E_PULSE;
    localparam int MAX_B = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = (MAX_W < 2) ? 1 : $clog2(MAX_W);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] E_LAST   = CW'(E_PULSE - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    typedef enum logic [2:0] {
        S_PWR, S_INIT, S_ADDR1, S_CHAR1, S_ADDR2, S_CHAR2, S_IDLE
    } state_t;

    typedef enum logic [2:0] {
        P_FETCH1, P_FETCH2, P_SETUP, P_PULSE, P_HOLD, P_WAIT
    } phase_t;

    state_t        state_q;
    phase_t        phase_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    init_step_q;
    logic [4:0]    index_q;
    logic          lcd_e_q;
    logic          lcd_rs_q;
    logic [7:0]    lcd_data_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          pending_q;

    logic          is_clear;
    logic [CW-1:0] wait_last;
    logic          wait_none;
    logic          write_done;

    // Function-set, display, entry-mode, clear
    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        case (step)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Decide when the current write has finished its post-write wait; only a clear
    // command (rs=0, data 0x01) gets the long wait, a 0x01 character does not.
    always_comb begin
        is_clear   = !lcd_rs_q && (lcd_data_q == CMD_CLEAR);
        wait_last  = is_clear ? CLR_LAST : CMD_LAST;
        wait_none  = is_clear ? (CLR_WAIT == 0) : (CMD_WAIT == 0);
        write_done = ((phase_q == P_HOLD) && wait_none) ||
                     ((phase_q == P_WAIT) && (cnt_q == wait_last));
    end

    // Top sequencer: power-on wait, init commands, two-line frame writes, refresh handling
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_PWR;
            phase_q      <= P_SETUP;
            cnt_q        <= '0;
            init_step_q  <= '0;
            index_q      <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (lcd.refresh && busy_q) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                S_PWR: begin
                    if ((PWR_WAIT <= 1) || (cnt_q == PWR_LAST)) begin
                        cnt_q       <= '0;
                        state_q     <= S_INIT;
                        phase_q     <= P_SETUP;
                        init_step_q <= 2'd0;
                        lcd_rs_q    <= 1'b0;
                        lcd_data_q  <= init_cmd(2'd0);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (lcd.refresh || pending_q) begin
                        state_q    <= S_ADDR1;
                        phase_q    <= P_SETUP;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        pending_q  <= 1'b0;
                        lcd_rs_q   <= 1'b0;
                        lcd_data_q <= CMD_LINE1;
                    end
                end
                default: begin
                    case (phase_q)
                        P_FETCH1: phase_q <= P_FETCH2;
                        P_FETCH2: begin
                            lcd_rs_q   <= 1'b1;
                            lcd_data_q <= lcd.char_in;
                            phase_q    <= P_SETUP;
                        end
                        P_SETUP: begin
                            lcd_e_q <= 1'b1;
                            cnt_q   <= '0;
                            phase_q <= P_PULSE;
                        end
                        P_PULSE: begin
                            if (cnt_q == E_LAST) begin
                                lcd_e_q <= 1'b0;
                                cnt_q   <= '0;
                                phase_q <= P_HOLD;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                        P_HOLD: begin
                            cnt_q   <= '0;
                            phase_q <= P_WAIT;
                        end
                        default: cnt_q <= cnt_q + 1'b1;
                    endcase

                    if (write_done) begin
                        cnt_q <= '0;
                        case (state_q)
                            S_INIT: begin
                                if (init_step_q == 2'd3) begin
                                    state_q    <= S_ADDR1;
                                    phase_q    <= P_SETUP;
                                    pending_q  <= 1'b0;
                                    lcd_rs_q   <= 1'b0;
                                    lcd_data_q <= CMD_LINE1;
                                end else begin
                                    init_step_q <= init_step_q + 2'd1;
                                    phase_q     <= P_SETUP;
                                    lcd_data_q  <= init_cmd(init_step_q + 2'd1);
                                end
                            end
                            S_ADDR1: begin
                                state_q <= S_CHAR1;
                                phase_q <= P_FETCH1;
                            end
                            S_CHAR1: begin
                                index_q <= index_q + 5'd1;
                                if (index_q == 5'd15) begin
                                    state_q    <= S_ADDR2;
                                    phase_q    <= P_SETUP;
                                    lcd_rs_q   <= 1'b0;
                                    lcd_data_q <= CMD_LINE2;
                                end else begin
                                    phase_q <= P_FETCH1;
                                end
                            end
                            S_ADDR2: begin
                                state_q <= S_CHAR2;
                                phase_q <= P_FETCH1;
                            end
                            default: begin
                                // index wraps 31 -> 0 here as it enters IDLE
                                index_q <= index_q + 5'd1;
                                if (index_q == 5'd31) begin
                                    state_q      <= S_IDLE;
                                    busy_q       <= 1'b0;
                                    frame_done_q <= 1'b1;
                                end else begin
                                    phase_q <= P_FETCH1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign lcd.index      = index_q;
    assign lcd.lcd_e      = lcd_e_q;
    assign lcd.lcd_rs     = lcd_rs_q;
    assign lcd.lcd_rw     = 1'b0;
    assign lcd.lcd_data   = lcd_data_q;
    assign lcd.busy       = busy_q;
    assign lcd.frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb/tb_lcd_refresh_ctrl.sv - Randomized self-checking bench for lcd_refresh_ctrl
module tb_lcd_refresh_ctrl;
    localparam int PWR_WAIT = 16;
    localparam int E_PULSE  = 4;
    localparam int CMD_WAIT = 8;
    localparam int CLR_WAIT = 32;
    localparam int FRAME_N  = 34;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_refresh_if bus ();

    lcd_refresh_ctrl #(
        .PWR_WAIT (PWR_WAIT),
        .E_PULSE  (E_PULSE),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lcd (bus)
    );

    int total = 0;
    int bad   = 0;

    // Display-list block: registered lookup, char valid one cycle after index is sampled
    logic [7:0] mem [32];
    always @(posedge clk) bus.char_in <= mem[bus.index];

    // Cycle number since reset release: k after the k-th active edge with rst high
    int cyc = 0;
    always @(posedge clk) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // LCD model: records e rises/falls, the byte latched on each fall, frame_done pulses
    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] wr_q[$];
    int         fd_q[$];
    int         stab_bad = 0;
    logic       e_prev   = 1'b0;
    logic       lat_rs;
    logic [7:0] lat_data;
    always @(negedge clk) begin
        if (!rst) begin
            e_prev = 1'b0;
        end else begin
            if (bus.lcd_e && !e_prev) begin
                rise_q.push_back(cyc);
                lat_rs   = bus.lcd_rs;
                lat_data = bus.lcd_data;
            end else if (bus.lcd_e || e_prev) begin
                if (bus.lcd_rs !== lat_rs || bus.lcd_data !== lat_data) stab_bad++;
            end
            if (!bus.lcd_e && e_prev) begin
                fall_q.push_back(cyc);
                wr_q.push_back({bus.lcd_rs, bus.lcd_data});
            end
            if (bus.frame_done === 1'b1) fd_q.push_back(cyc);
            e_prev = bus.lcd_e;
        end
    end

    logic [8:0] exp_q[$];

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        rise_q.delete();
        fall_q.delete();
        wr_q.delete();
        fd_q.delete();
        stab_bad = 0;
    endtask

    task automatic randomize_mem;
        foreach (mem[i]) mem[i] = 8'($urandom_range(32, 126));
    endtask

    // Expected LCD byte sequence for one frame, {rs, data}
    task automatic build_expected(input bit with_init);
        exp_q.delete();
        if (with_init) begin
            exp_q.push_back(9'h038);
            exp_q.push_back(9'h00C);
            exp_q.push_back(9'h006);
            exp_q.push_back(9'h001);
        end
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, mem[i]});
        exp_q.push_back(9'h0C0);
        for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, mem[i]});
    endtask

    // Cycles between e falls: previous write's wait + setup + pulse + hold (+ fetch for chars)
    function automatic int exp_gap(input logic [8:0] prev, input logic [8:0] cur);
        return ((prev == 9'h001) ? CLR_WAIT : CMD_WAIT) + 2 + E_PULSE + (cur[8] ? 2 : 0);
    endfunction

    task automatic wait_fd(input int n, input int budget, output bit ok,
                           output logic busy_now, output logic busy_prev);
        logic bp;
        ok        = 1'b0;
        busy_now  = 1'bx;
        busy_prev = 1'bx;
        for (int i = 0; i < budget; i++) begin
            bp = bus.busy;
            step();
            if (fd_q.size() >= n) begin
                ok        = 1'b1;
                busy_now  = bus.busy;
                busy_prev = bp;
                break;
            end
        end
    endtask

    task automatic pulse_refresh;
        bus.refresh = 1'b1;
        step();
        bus.refresh = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.refresh = 1'b0;
        repeat (3) step();
        total++; if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL reset_e: got %b want 0", bus.lcd_e); end
        total++; if (bus.lcd_rs !== 1'b0) begin bad++; $display("FAIL reset_rs: got %b want 0", bus.lcd_rs); end
        total++; if (bus.lcd_rw !== 1'b0) begin bad++; $display("FAIL reset_rw: got %b want 0", bus.lcd_rw); end
        total++; if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.lcd_data); end
        total++; if (bus.index !== 5'd0) begin bad++; $display("FAIL reset_index: got %0d want 0", bus.index); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    endtask

    task automatic test_first_frame;
        bit   ok;
        logic bn, bp;
        int   last;
        randomize_mem();
        build_expected(1'b1);
        clear_log();
        rst = 1'b1;
        wait_fd(1, 3000, ok, bn, bp);
        total++; if (!ok) begin bad++; $display("FAIL first_timeout: got no frame_done want 1 pulse"); end
        total++; if (rise_q.size() == 0 || rise_q[0] !== PWR_WAIT + 1) begin
            bad++; $display("FAIL first_rise_cycle: got %0d want %0d", (rise_q.size() != 0) ? rise_q[0] : -1, PWR_WAIT + 1);
        end
        total++; if (wr_q.size() !== exp_q.size()) begin bad++; $display("FAIL first_write_count: got %0d want %0d", wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL first_write[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
        for (int i = 0; i < rise_q.size() && i < fall_q.size(); i++) begin
            total++; if (fall_q[i] - rise_q[i] !== E_PULSE) begin bad++; $display("FAIL first_pulse_width[%0d]: got %0d want %0d", i, fall_q[i] - rise_q[i], E_PULSE); end
        end
        for (int i = 1; i < fall_q.size() && i < exp_q.size(); i++) begin
            total++; if (fall_q[i] - fall_q[i-1] !== exp_gap(exp_q[i-1], exp_q[i])) begin
                bad++; $display("FAIL first_gap[%0d]: got %0d want %0d", i, fall_q[i] - fall_q[i-1], exp_gap(exp_q[i-1], exp_q[i]));
            end
        end
        if (ok && fall_q.size() != 0) begin
            last = fall_q[fall_q.size()-1];
            total++; if (fd_q[0] !== last + 1 + CMD_WAIT) begin bad++; $display("FAIL first_fd_cycle: got %0d want %0d", fd_q[0], last + 1 + CMD_WAIT); end
            total++; if (bn !== 1'b0 || bp !== 1'b1) begin bad++; $display("FAIL first_busy_fall: got prev=%b now=%b want prev=1 now=0", bp, bn); end
            total++; if (bus.index !== 5'd0) begin bad++; $display("FAIL first_index_wrap: got %0d want 0", bus.index); end
        end
        step();
        total++; if (fd_q.size() !== 1) begin bad++; $display("FAIL first_fd_count: got %0d want 1", fd_q.size()); end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL first_bus_stable: got %0d changes want 0", stab_bad); end
    endtask

    task automatic test_refresh_idle;
        bit   ok;
        logic bn, bp;
        int   idle_busy = 0;
        int   nrise, s;
        nrise = rise_q.size();
        for (int i = 0; i < int'($urandom_range(3, 20)); i++) begin
            step();
            if (bus.busy !== 1'b0) idle_busy++;
        end
        total++; if (idle_busy !== 0 || rise_q.size() !== nrise) begin
            bad++; $display("FAIL idle_quiet: got busy_cycles=%0d new_rises=%0d want 0 0", idle_busy, rise_q.size() - nrise);
        end
        randomize_mem();
        mem[$urandom_range(0, 31)] = 8'h01;
        build_expected(1'b0);
        clear_log();
        s = cyc;
        pulse_refresh();
        wait_fd(1, 2000, ok, bn, bp);
        total++; if (!ok) begin bad++; $display("FAIL idle_timeout: got no frame_done want 1 pulse"); end
        total++; if (rise_q.size() == 0 || rise_q[0] !== s + 2) begin
            bad++; $display("FAIL idle_first_rise: got %0d want %0d", (rise_q.size() != 0) ? rise_q[0] : -1, s + 2);
        end
        total++; if (wr_q.size() !== FRAME_N) begin bad++; $display("FAIL idle_write_count: got %0d want %0d", wr_q.size(), FRAME_N); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL idle_write[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
        for (int i = 1; i < fall_q.size() && i < exp_q.size(); i++) begin
            total++; if (fall_q[i] - fall_q[i-1] !== exp_gap(exp_q[i-1], exp_q[i])) begin
                bad++; $display("FAIL idle_gap[%0d]: got %0d want %0d", i, fall_q[i] - fall_q[i-1], exp_gap(exp_q[i-1], exp_q[i]));
            end
        end
        total++; if (stab_bad !== 0) begin bad++; $display("FAIL idle_bus_stable: got %0d changes want 0", stab_bad); end
    endtask

    task automatic test_pending;
        bit   ok;
        logic bn, bp;
        int   t0, t1, t2, d;
        int   idle_pulses = 0;
        randomize_mem();
        build_expected(1'b0);
        clear_log();
        pulse_refresh();
        t0 = $urandom_range(10, 150);
        t1 = $urandom_range(160, 300);
        t2 = $urandom_range(310, 450);
        for (int c = 0; c < 460; c++) begin
            bus.refresh = (c == t0 || c == t1 || c == t2);
            if (bus.refresh && bus.busy !== 1'b1) idle_pulses++;
            step();
        end
        bus.refresh = 1'b0;
        total++; if (idle_pulses !== 0) begin bad++; $display("FAIL pend_busy_during_frame: got %0d idle samples want 0", idle_pulses); end
        wait_fd(1, 2000, ok, bn, bp);
        total++; if (!ok || bn !== 1'b0) begin bad++; $display("FAIL pend_first_done: got ok=%b busy=%b want ok=1 busy=0", ok, bn); end
        d = ok ? fd_q[0] : 0;
        step();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL pend_idle_one_cycle: got busy=%b want 1", bus.busy); end
        wait_fd(2, 2000, ok, bn, bp);
        total++; if (!ok) begin bad++; $display("FAIL pend_second_timeout: got no second frame_done want one"); end
        total++; if (rise_q.size() <= FRAME_N || rise_q[FRAME_N] !== d + 2) begin
            bad++; $display("FAIL pend_restart_cycle: got %0d want %0d", (rise_q.size() > FRAME_N) ? rise_q[FRAME_N] : -1, d + 2);
        end
        for (int i = 0; i < exp_q.size() && FRAME_N + i < wr_q.size(); i++) begin
            total++; if (wr_q[FRAME_N + i] !== exp_q[i]) begin bad++; $display("FAIL pend_write[%0d]: got %h want %h", i, wr_q[FRAME_N + i], exp_q[i]); end
        end
        repeat (700) step();
        total++; if (fd_q.size() !== 2) begin bad++; $display("FAIL pend_frame_count: got %0d want 2", fd_q.size()); end
        total++; if (wr_q.size() !== 2 * FRAME_N) begin bad++; $display("FAIL pend_write_count: got %0d want %0d", wr_q.size(), 2 * FRAME_N); end
    endtask

    task automatic test_refresh_on_done;
        bit   ok;
        logic bn, bp;
        int   d;
        clear_log();
        pulse_refresh();
        wait_fd(1, 2000, ok, bn, bp);
        total++; if (!ok) begin bad++; $display("FAIL done_first_timeout: got no frame_done want one"); end
        d = ok ? fd_q[0] : 0;
        pulse_refresh();
        wait_fd(2, 2000, ok, bn, bp);
        total++; if (!ok) begin bad++; $display("FAIL done_second_timeout: got no second frame_done want one"); end
        total++; if (rise_q.size() <= FRAME_N || rise_q[FRAME_N] !== d + 2) begin
            bad++; $display("FAIL done_restart_cycle: got %0d want %0d", (rise_q.size() > FRAME_N) ? rise_q[FRAME_N] : -1, d + 2);
        end
        total++; if (wr_q.size() <= FRAME_N || wr_q[FRAME_N] !== 9'h080) begin
            bad++; $display("FAIL done_restart_cmd: got %h want 080", (wr_q.size() > FRAME_N) ? wr_q[FRAME_N] : 9'h1FF);
        end
    endtask

    task automatic test_reset_mid_write;
        bit   ok;
        logic bn, bp;
        bit   hit = 1'b0;
        randomize_mem();
        build_expected(1'b1);
        clear_log();
        pulse_refresh();
        for (int i = 0; i < 2000 && !hit; i++) begin
            step();
            hit = (rise_q.size() == 23) && (bus.lcd_e === 1'b1);
        end
        total++; if (!hit || bus.index !== 5'd20) begin bad++; $display("FAIL mid_reach_char20: got hit=%b index=%0d want 1 20", hit, bus.index); end
        rst = 1'b0;
        step();
        total++; if (bus.lcd_e !== 1'b0) begin bad++; $display("FAIL mid_reset_e: got %b want 0", bus.lcd_e); end
        total++; if (bus.index !== 5'd0) begin bad++; $display("FAIL mid_reset_index: got %0d want 0", bus.index); end
        total++; if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL mid_reset_data: got %h want 00", bus.lcd_data); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_reset_busy: got %b want 1", bus.busy); end
        clear_log();
        rst = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            hit = (rise_q.size() != 0);
        end
        total++; if (!hit || rise_q[0] !== PWR_WAIT + 1 || bus.lcd_data !== 8'h38 || bus.lcd_rs !== 1'b0) begin
            bad++; $display("FAIL mid_rerun_init: got hit=%b cycle=%0d data=%h rs=%b want 1 %0d 38 0",
                            hit, hit ? rise_q[0] : -1, bus.lcd_data, bus.lcd_rs, PWR_WAIT + 1);
        end
        wait_fd(1, 3000, ok, bn, bp);
        total++; if (!ok || wr_q.size() !== exp_q.size()) begin bad++; $display("FAIL mid_full_frame: got ok=%b writes=%0d want 1 %0d", ok, wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            total++; if (wr_q[i] !== exp_q[i]) begin bad++; $display("FAIL mid_write[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.refresh = 1'b0;
        foreach (mem[i]) mem[i] = 8'h20;
        test_reset();
        test_first_frame();
        test_refresh_idle();
        test_pending();
        test_refresh_on_done();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
